// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the pipeline stage registers.
// Control bit positions and per-stage bundle widths used by the core's instantiators.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

   localparam int CTRL_MEMREAD  = 0;
   localparam int CTRL_MEMWRITE = 1;
   localparam int CTRL_ALUORMEM = 2;
   localparam int CTRL_BEQ      = 3;
   localparam int CTRL_BNE      = 4;
   localparam int CTRL_REGWRITE = 5;
   localparam int CTRL_JUMP     = 6;
   localparam int CTRL_ALUSRC   = 7;

   localparam int IFID_DATA_W  = 64;   // pc + instruction
   localparam int IFID_CTRL_W  = 1;
   localparam int IDEX_DATA_W  = 112;  // pc + rs1 + rs2 + imm (16b)
   localparam int IDEX_CTRL_W  = 8;
   localparam int EXMEM_DATA_W = 69;   // alu + store data + rd
   localparam int EXMEM_CTRL_W = 4;
   localparam int MEMWB_DATA_W = 69;   // load data + alu + rd
   localparam int MEMWB_CTRL_W = 2;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-to-stage handshake bundle: upstream valid/ready, downstream valid/ready, flush, stall count.
// master = side driving entries in and taking them out; slave = the stage register itself.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [31:0]       out_stall_cnt;

   modport master (
      output in_valid, in_data, in_ctrl, flush, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, out_stall_cnt
   );

   modport slave (
      input  in_valid, in_data, in_ctrl, flush, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, out_stall_cnt
   );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One data+ctrl+valid holding register, updated on the falling edge.
// Latency: one edge from load to outputs.
// Backpressure: none; clear beats load, clear keeps data but zeroes ctrl/valid.
module pipe_slot #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] dataIn,
   input  logic [CTRL_W-1:0] ctrlIn,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);
   always_ff @(negedge clk) begin
      if (!reset) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= dataIn;
         ctrl  <= ctrlIn;
      end
   end
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with flush; optional stall counter under PIPE_STAGE_STALL_CNT_EN.
// Latency: one falling edge from accept to out_*.
// Backpressure: SKID=1 registered in_ready via 2-entry skid; SKID=0 in_ready = ~out_valid | out_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int SKID   = 1
) (
   input  logic             clk,
   input  logic             reset,
   pipe_stage_reg_if.slave  bus
);
   logic              accept;
   logic              pop;
   logic              mainLoad;
   logic              mainClear;
   logic              mainValid;
   logic [DATA_W-1:0] mainDataIn;
   logic [CTRL_W-1:0] mainCtrlIn;
   logic [DATA_W-1:0] mainData;
   logic [CTRL_W-1:0] mainCtrl;

   assign accept = bus.in_valid & bus.in_ready;
   assign pop    = mainValid & bus.out_ready;

   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) mainSlot (
      .clk    (clk),
      .reset  (reset),
      .load   (mainLoad),
      .clear  (mainClear),
      .dataIn (mainDataIn),
      .ctrlIn (mainCtrlIn),
      .valid  (mainValid),
      .data   (mainData),
      .ctrl   (mainCtrl)
   );

   generate
      if (SKID != 0) begin : gSkid
         stage_state_t      state;
         stage_state_t      stateNext;
         logic              inReadyQ;
         logic              useSkid;
         logic              skidLoad;
         logic              skidClear;
         logic              skidValid;
         logic [DATA_W-1:0] skidData;
         logic [CTRL_W-1:0] skidCtrl;

         pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) skidSlot (
            .clk    (clk),
            .reset  (reset),
            .load   (skidLoad),
            .clear  (skidClear),
            .dataIn (bus.in_data),
            .ctrlIn (bus.in_ctrl),
            .valid  (skidValid),
            .data   (skidData),
            .ctrl   (skidCtrl)
         );

         always_comb begin
            stateNext = state;
            mainLoad  = 1'b0;
            mainClear = bus.flush;
            skidLoad  = 1'b0;
            skidClear = bus.flush;
            useSkid   = 1'b0;
            if (bus.flush) begin
               stateNext = EMPTY;
            end else begin
               case (state)
                  EMPTY: begin
                     if (accept) begin
                        mainLoad  = 1'b1;
                        stateNext = ONE;
                     end
                  end
                  ONE: begin
                     if (accept && pop) begin
                        mainLoad = 1'b1;
                     end else if (accept) begin
                        skidLoad  = 1'b1;
                        stateNext = FULL;
                     end else if (pop) begin
                        mainClear = 1'b1;
                        stateNext = EMPTY;
                     end
                  end
                  FULL: begin
                     // The skid entry is older than nothing else held, so it moves up to main.
                     if (pop && skidValid) begin
                        mainLoad  = 1'b1;
                        useSkid   = 1'b1;
                        skidClear = 1'b1;
                        stateNext = ONE;
                     end
                  end
                  default: stateNext = EMPTY;
               endcase
            end
         end

         always_ff @(negedge clk) begin
            if (!reset) begin
               state    <= EMPTY;
               inReadyQ <= 1'b1;
            end else begin
               state    <= stateNext;
               inReadyQ <= (stateNext != FULL);
            end
         end

         assign mainDataIn   = useSkid ? skidData : bus.in_data;
         assign mainCtrlIn   = useSkid ? skidCtrl : bus.in_ctrl;
         assign bus.in_ready = inReadyQ;
      end else begin : gSingle
         assign bus.in_ready = ~mainValid | bus.out_ready;
         assign mainLoad     = accept;
         assign mainClear    = bus.flush | (pop & ~accept);
         assign mainDataIn   = bus.in_data;
         assign mainCtrlIn   = bus.in_ctrl;
      end
   endgenerate

   assign bus.out_valid = mainValid;
   assign bus.out_data  = mainData;
   assign bus.out_ctrl  = mainValid ? mainCtrl : '0;

`ifdef PIPE_STAGE_STALL_CNT_EN
   logic [31:0] stallCnt;

   // Flush does not clear the counter; only reset does.
   always_ff @(negedge clk) begin
      if (!reset) begin
         stallCnt <= '0;
      end else if (mainValid && !bus.out_ready && (stallCnt != 32'hFFFF_FFFF)) begin
         stallCnt <= stallCnt + 32'd1;
      end
   end

   assign bus.out_stall_cnt = stallCnt;
`else
   assign bus.out_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, directed stimulus, scoreboard monitors.
// State changes on the falling edge; inputs change at posedge+1, monitors sample at posedge+2.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   typedef struct {
      logic [31:0] d;
      logic [7:0]  c;
   } exp_t;

`ifdef PIPE_STAGE_STALL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk;
   logic reset;
   logic monEn;
   int   checks;
   int   errors;
   exp_t qA[$];
   exp_t qB[$];

   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) ifA ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) ifB ();

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (ifA)
   );

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (ifB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitors: a pop is an edge with out_valid & out_ready, no flush, no reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (monEn) begin
            if (reset && !ifA.flush && ifA.out_valid && ifA.out_ready) begin
               if (qA.size() == 0) begin
                  chk("A_unexpected_pop", ifA.out_data, 32'hDEAD_BEEF);
               end else begin
                  e = qA.pop_front();
                  chk("A_pop_data", ifA.out_data, e.d);
                  chk("A_pop_ctrl", {24'd0, ifA.out_ctrl}, {24'd0, e.c});
               end
            end
            if (!ifA.out_valid) chk("A_bubble_ctrl", {24'd0, ifA.out_ctrl}, 32'd0);
            if (reset && !ifB.flush && ifB.out_valid && ifB.out_ready) begin
               if (qB.size() == 0) begin
                  chk("B_unexpected_pop", ifB.out_data, 32'hDEAD_BEEF);
               end else begin
                  e = qB.pop_front();
                  chk("B_pop_data", ifB.out_data, e.d);
                  chk("B_pop_ctrl", {24'd0, ifB.out_ctrl}, {24'd0, e.c});
               end
            end
            if (!ifB.out_valid) chk("B_bubble_ctrl", {24'd0, ifB.out_ctrl}, 32'd0);
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      monEn  = 1'b0;
      reset  = 1'b0;
      ifA.in_valid = 1'b1; ifA.in_data = 32'h77; ifA.in_ctrl = 8'hFF;
      ifA.flush = 1'b0;    ifA.out_ready = 1'b1;
      ifB.in_valid = 1'b1; ifB.in_data = 32'h77; ifB.in_ctrl = 8'hFF;
      ifB.flush = 1'b0;    ifB.out_ready = 1'b1;

      // Reset held across two falling edges with in_valid high
      step(); step(); step();
      chk("rst_A_out_valid", {31'd0, ifA.out_valid}, 32'd0);
      chk("rst_A_out_data", ifA.out_data, 32'd0);
      chk("rst_B_out_valid", {31'd0, ifB.out_valid}, 32'd0);
      reset = 1'b1;
      ifA.in_valid = 1'b0;
      ifB.in_valid = 1'b0;
      step();
      chk("rst_A_in_ready", {31'd0, ifA.in_ready}, 32'd1);
      chk("rst_B_in_ready", {31'd0, ifB.in_ready}, 32'd1);
      chk("rst_A_out_ctrl", {24'd0, ifA.out_ctrl}, 32'd0);
      chk("rst_A_stall_cnt", ifA.out_stall_cnt, 32'd0);
      monEn = 1'b1;

      // Streaming 1..5 through the skid stage
      ifA.out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         ifA.in_valid = 1'b1;
         ifA.in_data  = i;
         ifA.in_ctrl  = 8'h10 + 8'(i);
         qA.push_back('{d: i, c: 8'h10 + 8'(i)});
         step();
         chk("stream_in_ready", {31'd0, ifA.in_ready}, 32'd1);
         if (i == 1) chk("stream_first_data", ifA.out_data, 32'd1);
      end
      ifA.in_valid = 1'b0;
      step(); step();

      // Backpressure fills main then skid
      ifA.out_ready = 1'b0;
      ifA.in_valid  = 1'b1; ifA.in_data = 32'hA; ifA.in_ctrl = 8'h0A;
      qA.push_back('{d: 32'hA, c: 8'h0A});
      step();
      ifA.in_data = 32'hB; ifA.in_ctrl = 8'h0B;
      qA.push_back('{d: 32'hB, c: 8'h0B});
      step();
      ifA.in_valid = 1'b0;
      chk("bp_full_in_ready", {31'd0, ifA.in_ready}, 32'd0);
      chk("bp_head_data", ifA.out_data, 32'hA);
      chk("bp_out_valid", {31'd0, ifA.out_valid}, 32'd1);
      ifA.out_ready = 1'b1;
      step();
      chk("bp_in_ready_after_pop", {31'd0, ifA.in_ready}, 32'd1);
      chk("bp_second_data", ifA.out_data, 32'hB);
      step();
      chk("bp_drained", {31'd0, ifA.out_valid}, 32'd0);

      // Flush beats a simultaneous accept
      ifA.out_ready = 1'b0;
      ifA.in_valid  = 1'b1; ifA.in_data = 32'h10; ifA.in_ctrl = 8'h1F;
      step();
      chk("fl_hold_data", ifA.out_data, 32'h10);
      ifA.in_data = 32'h20; ifA.in_ctrl = 8'h2F; ifA.flush = 1'b1;
      step();
      ifA.flush = 1'b0; ifA.in_valid = 1'b0;
      chk("fl_out_valid", {31'd0, ifA.out_valid}, 32'd0);
      chk("fl_out_ctrl", {24'd0, ifA.out_ctrl}, 32'd0);
      chk("fl_data_held", ifA.out_data, 32'h10);
      chk("fl_in_ready", {31'd0, ifA.in_ready}, 32'd1);
      ifA.out_ready = 1'b1;
      step(); step();
      chk("fl_stays_empty", {31'd0, ifA.out_valid}, 32'd0);

      // Flush from FULL, then a fresh entry is the only thing delivered
      ifA.out_ready = 1'b0;
      ifA.in_valid  = 1'b1; ifA.in_data = 32'h21; ifA.in_ctrl = 8'h21;
      step();
      ifA.in_data = 32'h22; ifA.in_ctrl = 8'h22;
      step();
      ifA.in_valid = 1'b0; ifA.flush = 1'b1;
      step();
      ifA.flush = 1'b0;
      chk("flfull_out_valid", {31'd0, ifA.out_valid}, 32'd0);
      chk("flfull_in_ready", {31'd0, ifA.in_ready}, 32'd1);
      ifA.out_ready = 1'b1;
      ifA.in_valid  = 1'b1; ifA.in_data = 32'h30; ifA.in_ctrl = 8'h3C;
      qA.push_back('{d: 32'h30, c: 8'h3C});
      step();
      ifA.in_valid = 1'b0;
      chk("flfull_new_data", ifA.out_data, 32'h30);
      step(); step();

      // SKID=0: held entry stalls for 7 edges
      ifB.out_ready = 1'b0;
      ifB.in_valid  = 1'b1; ifB.in_data = 32'h44; ifB.in_ctrl = 8'h44;
      qB.push_back('{d: 32'h44, c: 8'h44});
      step();
      ifB.in_valid = 1'b0;
      chk("s0_out_valid", {31'd0, ifB.out_valid}, 32'd1);
      chk("s0_in_ready_blocked", {31'd0, ifB.in_ready}, 32'd0);
      repeat (7) step();
      chk("stall_cnt_7", ifB.out_stall_cnt, CNT_EN ? 32'd7 : 32'd0);
      ifB.out_ready = 1'b1;
      ifB.in_valid  = 1'b1; ifB.in_data = 32'h33; ifB.in_ctrl = 8'h03;
      qB.push_back('{d: 32'h33, c: 8'h03});
      #1;
      chk("s0_in_ready_comb", {31'd0, ifB.in_ready}, 32'd1);
      step();
      chk("s0_replace_data", ifB.out_data, 32'h33);
      chk("s0_replace_valid", {31'd0, ifB.out_valid}, 32'd1);
      ifB.in_valid = 1'b0;
      step(); step();

      // SKID=0 flush priority; counter unaffected
      ifB.out_ready = 1'b0;
      ifB.in_valid  = 1'b1; ifB.in_data = 32'h55; ifB.in_ctrl = 8'h55;
      step();
      ifB.out_ready = 1'b1; ifB.in_data = 32'h66; ifB.in_ctrl = 8'h66; ifB.flush = 1'b1;
      step();
      ifB.flush = 1'b0; ifB.in_valid = 1'b0;
      chk("s0_fl_out_valid", {31'd0, ifB.out_valid}, 32'd0);
      chk("s0_fl_data_held", ifB.out_data, 32'h55);
      chk("stall_cnt_after_flush", ifB.out_stall_cnt, CNT_EN ? 32'd7 : 32'd0);
      step();

      // Reset and flush together: reset values win
      ifA.out_ready = 1'b0;
      ifA.in_valid  = 1'b1; ifA.in_data = 32'h77; ifA.in_ctrl = 8'h77;
      step();
      ifA.in_valid = 1'b0;
      chk("rf_pre_valid", {31'd0, ifA.out_valid}, 32'd1);
      reset = 1'b0; ifA.flush = 1'b1; ifB.flush = 1'b1;
      step();
      chk("rf_A_out_data", ifA.out_data, 32'd0);
      chk("rf_A_out_valid", {31'd0, ifA.out_valid}, 32'd0);
      chk("rf_B_stall_cnt", ifB.out_stall_cnt, 32'd0);
      reset = 1'b1; ifA.flush = 1'b0; ifB.flush = 1'b0;
      step();
      chk("rf_A_in_ready", {31'd0, ifA.in_ready}, 32'd1);

      chk("A_queue_drained", qA.size(), 32'd0);
      chk("B_queue_drained", qB.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
